router_out_arbiter: RTL and testbench

ROUTER_OUT_ARBITER -- requirements
Module: router_out_arbiter

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_out_arbiter_if.sv | 26 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/router_out_arbiter.sv | 142 ++++++++++++++
 tb/tb_router_out_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared types for the router output arbiter: flit container, arbiter FSM states
// and the fixed port indices of the four competing input channels.
package router_pkg;

    localparam int FLIT_DATA_W = 32;

    localparam int SELF = 0;
    localparam int NS   = 1;
    localparam int WE   = 2;
    localparam int DIAG = 3;

    typedef struct packed {
        logic                   head;
        logic                   tail;
        logic [FLIT_DATA_W-1:0] payload;
    } flit_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/router_out_arbiter_if.sv
// Handshake bundle between the competing input channels, the arbiter and the
// downstream output link. The arbiter uses the slave view, its environment the master view.
interface router_out_arbiter_if #(
    parameter int NUM_IN = 4
);

    logic              [NUM_IN-1:0] in_valid_i;
    router_pkg::flit_t [NUM_IN-1:0] in_flit_i;
    logic              [NUM_IN-1:0] in_ready_o;
    logic                           out_valid_o;
    router_pkg::flit_t              out_flit_o;
    logic                           out_ready_i;
    logic              [NUM_IN-1:0] grant_o;
    logic              [15:0]       pkt_cnt_o;

    modport master (
        output in_valid_i, in_flit_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_flit_o, grant_o, pkt_cnt_o
    );

    modport slave (
        input  in_valid_i, in_flit_i, out_ready_i,
        output in_ready_o, out_valid_o, out_flit_o, grant_o, pkt_cnt_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after ptr_i,
// wrapping NUM_IN-1 -> 0, wins a one-hot grant.
module rr_arbiter #(
    parameter int NUM_IN = 4,
    parameter int PTR_W  = 2
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [NUM_IN-1:0] gnt_o
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int off = 0; off < NUM_IN; off++) begin
            sum = {1'b0, ptr_i} + (PTR_W+1)'(off);
            if (sum >= (PTR_W+1)'(NUM_IN)) begin
                sum = sum - (PTR_W+1)'(NUM_IN);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_out_arbiter.sv
// Wormhole output-port arbiter: locks one input from head to tail and forwards its flits
// through a one-deep output register. Define ROUTER_OUTARB_PKTCNT_EN to count forwarded packets.
module router_out_arbiter
    import router_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 32
) (
    input logic                 clk_i,
    input logic                 rst_i,
    router_out_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    // Payload rides in the package-wide container; narrower builds zero the unused upper bits.
    localparam logic [FLIT_DATA_W-1:0] PAYLOAD_MASK = {FLIT_DATA_W{1'b1}} >> (FLIT_DATA_W - DATA_W);

    arb_state_t        state_q, state_d;
    logic [NUM_IN-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              out_valid_q, out_valid_d;
    flit_t             out_flit_q, out_flit_d;

    logic [NUM_IN-1:0] cand;
    logic [NUM_IN-1:0] arb_gnt;
    logic [NUM_IN-1:0] in_ready;
    logic [PTR_W-1:0]  grant_idx;
    flit_t             sel_flit;
    logic              out_free;
    logic              accept;

    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            cand[i] = bus.in_valid_i[i] & bus.in_flit_i[i].head;
        end
    end

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .PTR_W  (PTR_W)
    ) u_rr_arbiter (
        .req_i  (cand),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (arb_gnt)
    );

    assign out_free = !out_valid_q || bus.out_ready_i;
    assign in_ready = (state_q == LOCKED && !rst_i) ? (grant_q & {NUM_IN{out_free}}) : '0;
    assign accept   = |(in_ready & bus.in_valid_i);

    always_comb begin
        sel_flit  = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_q[i]) begin
                sel_flit  = bus.in_flit_i[i];
                grant_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;

        if (out_valid_q && bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (|cand) begin
                    grant_d = arb_gnt;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (accept) begin
                    out_valid_d        = 1'b1;
                    out_flit_d         = sel_flit;
                    out_flit_d.payload = sel_flit.payload & PAYLOAD_MASK;
                    if (sel_flit.tail) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = (grant_idx == PTR_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_flit_o  = out_flit_q;
    assign bus.grant_o     = grant_q;

`ifdef ROUTER_OUTARB_PKTCNT_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (out_valid_q && bus.out_ready_i && out_flit_q.tail) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign bus.pkt_cnt_o = pkt_cnt_q;
`else
    assign bus.pkt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_router_out_arbiter.sv
// Self-checking bench for router_out_arbiter: arbitration vector table, scoreboard on the
// output link, and hand-written sequences for streaming, locking, back-pressure and reset.
module tb_router_out_arbiter;
    import router_pkg::*;

    localparam int NUM_IN = 4;

    typedef struct {
        int         pre;
        logic [3:0] valid;
        logic [3:0] head;
        logic [3:0] exp_grant;
    } arb_vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    router_out_arbiter_if #(.NUM_IN(NUM_IN)) bus ();

    router_out_arbiter #(
        .NUM_IN (NUM_IN),
        .DATA_W (32)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    flit_t exp_q[$];
    logic  sb_en = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic flit_t mk(input logic h, input logic t, input logic [31:0] p);
        flit_t f;
        f.head    = h;
        f.tail    = t;
        f.payload = p;
        return f;
    endfunction

    // Scoreboard: every output transfer must match the oldest accepted input flit.
    always @(negedge clk) begin
        if (!rst && sb_en && bus.out_valid_o && bus.out_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: actual=%0h expected=no output", bus.out_flit_o);
            end else begin
                check("sb_flit", 64'(bus.out_flit_o), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: actual=time limit reached expected=bench completion");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.in_valid_i = '0;
        bus.in_flit_i  = '0;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.out_ready_i = 1'b1;
        clear_inputs();
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_flit(input int idx, input flit_t f);
        bit done = 1'b0;
        bus.in_valid_i[idx] = 1'b1;
        bus.in_flit_i[idx]  = f;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus.in_ready_o[idx]) begin
                exp_q.push_back(f);
                done = 1'b1;
            end
            tick();
        end
        bus.in_valid_i[idx] = 1'b0;
        check($sformatf("send_accept[%0d]", idx), 64'(done), 64'(1));
    endtask

    task automatic wait_drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
        tick();
    endtask

    arb_vec_t vecs[10];

    initial begin
        vecs[0] = '{pre: -1, valid: 4'b0000, head: 4'b0000, exp_grant: 4'b0000};
        vecs[1] = '{pre: -1, valid: 4'b1111, head: 4'b0000, exp_grant: 4'b0000};
        vecs[2] = '{pre: -1, valid: 4'b1010, head: 4'b1010, exp_grant: 4'b0010};
        vecs[3] = '{pre: -1, valid: 4'b0101, head: 4'b0101, exp_grant: 4'b0001};
        vecs[4] = '{pre: -1, valid: 4'b1100, head: 4'b0100, exp_grant: 4'b0100};
        vecs[5] = '{pre:  0, valid: 4'b1111, head: 4'b1111, exp_grant: 4'b0010};
        vecs[6] = '{pre:  1, valid: 4'b0011, head: 4'b0011, exp_grant: 4'b0001};
        vecs[7] = '{pre:  3, valid: 4'b1000, head: 4'b1000, exp_grant: 4'b1000};
        vecs[8] = '{pre:  2, valid: 4'b1110, head: 4'b0110, exp_grant: 4'b0010};
        vecs[9] = '{pre:  2, valid: 4'b1111, head: 4'b1111, exp_grant: 4'b1000};

        // Reset state while every input offers a head flit.
        rst             = 1'b1;
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = '1;
        for (int i = 0; i < NUM_IN; i++) bus.in_flit_i[i] = mk(1'b1, 1'b0, 32'hA0 + 32'(i));
        tick();
        tick();
        @(negedge clk);
        check("rst_grant", 64'(bus.grant_o), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid_o), 64'(0));
        check("rst_out_flit", 64'(bus.out_flit_o), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready_o), 64'(0));
        check("rst_pkt_cnt", 64'(bus.pkt_cnt_o), 64'(0));
        tick();

        // Arbitration table: optional single-flit packet to move rr_ptr, then a request pattern.
        for (int v = 0; v < 10; v++) begin
            do_reset();
            if (vecs[v].pre >= 0) begin
                send_flit(vecs[v].pre, mk(1'b1, 1'b1, 32'h100 + 32'(v)));
                wait_drain();
            end
            for (int i = 0; i < NUM_IN; i++) begin
                bus.in_valid_i[i] = vecs[v].valid[i];
                bus.in_flit_i[i]  = mk(vecs[v].head[i], 1'b1, 32'h200 + 32'(i));
            end
            @(negedge clk);
            check($sformatf("arb_idle_ready[%0d]", v), 64'(bus.in_ready_o), 64'(0));
            tick();
            @(negedge clk);
            check($sformatf("arb_grant[%0d]", v), 64'(bus.grant_o), 64'(vecs[v].exp_grant));
            for (int i = 0; i < NUM_IN; i++) begin
                if (vecs[v].exp_grant[i]) exp_q.push_back(mk(vecs[v].head[i], 1'b1, 32'h200 + 32'(i)));
            end
            tick();
            clear_inputs();
            wait_drain();
`ifndef ROUTER_OUTARB_PKTCNT_EN
            check($sformatf("pkt_cnt_off[%0d]", v), 64'(bus.pkt_cnt_o), 64'(0));
`endif
        end

        // Input NS streams head, body, tail back to back.
        do_reset();
        bus.in_valid_i[NS] = 1'b1;
        bus.in_flit_i[NS]  = mk(1'b1, 1'b0, 32'h11);
        @(negedge clk);
        check("s3_idle_grant", 64'(bus.grant_o), 64'(0));
        check("s3_idle_ready", 64'(bus.in_ready_o), 64'(0));
        tick();
        @(negedge clk);
        check("s3_grant", 64'(bus.grant_o), 64'(4'b0010));
        check("s3_ready", 64'(bus.in_ready_o), 64'(4'b0010));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h11));
        tick();
        bus.in_flit_i[NS] = mk(1'b0, 1'b0, 32'h22);
        @(negedge clk);
        check("s3_lat_valid", 64'(bus.out_valid_o), 64'(1));
        check("s3_lat_head", 64'(bus.out_flit_o), 64'(mk(1'b1, 1'b0, 32'h11)));
        check("s3_ready_body", 64'(bus.in_ready_o), 64'(4'b0010));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h22));
        tick();
        bus.in_flit_i[NS] = mk(1'b0, 1'b1, 32'h33);
        @(negedge clk);
        check("s3_lat_body", 64'(bus.out_flit_o), 64'(mk(1'b0, 1'b0, 32'h22)));
        exp_q.push_back(mk(1'b0, 1'b1, 32'h33));
        tick();
        bus.in_valid_i[NS] = 1'b0;
        @(negedge clk);
        check("s3_lat_tail", 64'(bus.out_flit_o), 64'(mk(1'b0, 1'b1, 32'h33)));
        check("s3_grant_released", 64'(bus.grant_o), 64'(0));
        wait_drain();

        // Inputs SELF and WE hold single-flit packets together: SELF, bubble, WE, then rr_ptr=3.
        do_reset();
        bus.in_valid_i[SELF] = 1'b1;
        bus.in_flit_i[SELF]  = mk(1'b1, 1'b1, 32'h5E1F);
        bus.in_valid_i[WE]   = 1'b1;
        bus.in_flit_i[WE]    = mk(1'b1, 1'b1, 32'h3E00);
        tick();
        @(negedge clk);
        check("rr_first_grant", 64'(bus.grant_o), 64'(4'b0001));
        exp_q.push_back(mk(1'b1, 1'b1, 32'h5E1F));
        tick();
        bus.in_valid_i[SELF] = 1'b0;
        @(negedge clk);
        check("rr_bubble_grant", 64'(bus.grant_o), 64'(0));
        check("rr_bubble_ready", 64'(bus.in_ready_o), 64'(0));
        tick();
        @(negedge clk);
        check("rr_second_grant", 64'(bus.grant_o), 64'(4'b0100));
        exp_q.push_back(mk(1'b1, 1'b1, 32'h3E00));
        tick();
        bus.in_valid_i[WE] = 1'b0;
        wait_drain();
        for (int i = 0; i < NUM_IN; i++) begin
            bus.in_valid_i[i] = 1'b1;
            bus.in_flit_i[i]  = mk(1'b1, 1'b0, 32'h700 + 32'(i));
        end
        tick();
        @(negedge clk);
        check("rr_ptr_is_3", 64'(bus.grant_o), 64'(4'b1000));
        tick();

        // NS locked mid-packet; DIAG offers a head and must wait for NS's tail.
        do_reset();
        send_flit(NS, mk(1'b1, 1'b0, 32'hB1));
        bus.in_valid_i[DIAG] = 1'b1;
        bus.in_flit_i[DIAG]  = mk(1'b1, 1'b1, 32'hC1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("lock_diag_ready", 64'(bus.in_ready_o[DIAG]), 64'(0));
            check("lock_grant", 64'(bus.grant_o), 64'(4'b0010));
            tick();
        end
        send_flit(NS, mk(1'b1, 1'b0, 32'hB2));
        check("lock_after_head", 64'(bus.grant_o), 64'(4'b0010));
        send_flit(NS, mk(1'b0, 1'b1, 32'hB3));
        @(negedge clk);
        check("lock_bubble_grant", 64'(bus.grant_o), 64'(0));
        check("lock_bubble_ready", 64'(bus.in_ready_o[DIAG]), 64'(0));
        tick();
        @(negedge clk);
        check("lock_diag_grant", 64'(bus.grant_o), 64'(4'b1000));
        check("lock_diag_ready_up", 64'(bus.in_ready_o[DIAG]), 64'(1));
        exp_q.push_back(mk(1'b1, 1'b1, 32'hC1));
        tick();
        clear_inputs();
        wait_drain();

        // Downstream stalls for 5 cycles with a flit held.
        do_reset();
        send_flit(SELF, mk(1'b1, 1'b0, 32'hA1));
        bus.out_ready_i      = 1'b0;
        bus.in_valid_i[SELF] = 1'b1;
        bus.in_flit_i[SELF]  = mk(1'b0, 1'b0, 32'hA2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_valid", 64'(bus.out_valid_o), 64'(1));
            check("stall_flit", 64'(bus.out_flit_o), 64'(mk(1'b1, 1'b0, 32'hA1)));
            check("stall_ready", 64'(bus.in_ready_o[SELF]), 64'(0));
            tick();
        end
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        check("stall_resume_ready", 64'(bus.in_ready_o[SELF]), 64'(1));
        exp_q.push_back(mk(1'b0, 1'b0, 32'hA2));
        tick();
        bus.in_valid_i[SELF] = 1'b0;
        @(negedge clk);
        check("stall_resume_flit", 64'(bus.out_flit_o), 64'(mk(1'b0, 1'b0, 32'hA2)));
        tick();
        send_flit(SELF, mk(1'b0, 1'b1, 32'hA3));
        wait_drain();

        // Reset while locked and holding 0xDEADBEEF.
        do_reset();
        send_flit(NS, mk(1'b1, 1'b0, 32'hDEADBEEF));
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        check("mid_rst_held", 64'(bus.out_flit_o.payload), 64'(32'hDEADBEEF));
        tick();
        rst = 1'b1;
        exp_q.delete();
        bus.in_valid_i[NS]   = 1'b1;
        bus.in_flit_i[NS]    = mk(1'b0, 1'b0, 32'hBAD);
        bus.in_valid_i[DIAG] = 1'b1;
        bus.in_flit_i[DIAG]  = mk(1'b1, 1'b1, 32'hD1A6);
        @(negedge clk);
        check("mid_rst_ready", 64'(bus.in_ready_o), 64'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(bus.out_valid_o), 64'(0));
        check("mid_rst_grant", 64'(bus.grant_o), 64'(0));
        check("mid_rst_out_flit", 64'(bus.out_flit_o), 64'(0));
        tick();
        @(negedge clk);
        check("mid_rst_rearb", 64'(bus.grant_o), 64'(4'b1000));
        exp_q.push_back(mk(1'b1, 1'b1, 32'hD1A6));
        tick();
        clear_inputs();
        bus.out_ready_i = 1'b1;
        wait_drain();

`ifdef ROUTER_OUTARB_PKTCNT_EN
        // Preload the counter with 65535 packets, then one more wraps it to zero.
        begin
            int n = 0;
            int c = 0;
            do_reset();
            sb_en = 1'b0;
            bus.in_valid_i[SELF] = 1'b1;
            bus.in_flit_i[SELF]  = mk(1'b1, 1'b1, 32'h0);
            while (n < 65535 && c < 200000) begin
                @(negedge clk);
                if (bus.in_ready_o[SELF]) n++;
                c++;
            end
            tick();
            bus.in_valid_i[SELF] = 1'b0;
            tick();
            tick();
            @(negedge clk);
            check("pkt_cnt_ffff", 64'(bus.pkt_cnt_o), 64'(16'hFFFF));
            tick();
            sb_en = 1'b1;
            send_flit(WE, mk(1'b1, 1'b1, 32'h1234));
            wait_drain();
            @(negedge clk);
            check("pkt_cnt_wrap", 64'(bus.pkt_cnt_o), 64'(16'h0000));
            tick();
        end
`else
        @(negedge clk);
        check("pkt_cnt_tied", 64'(bus.pkt_cnt_o), 64'(0));
        tick();
`endif

        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
